// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
//   Stack pointer unit that sequences multi-byte push/pull bus cycles into a
//   fixed stack page. A push writes at {PAGE, sp} then post-decrements sp; a
//   pull pre-increments and reads at {PAGE, sp+1}. One bus cycle per clock.
//
//   Optional feature: define STACK_WRAP_DET_EN to enable the sticky wrap_flag
//   (set when a push decrements sp from 0 or a pull increments it from all
//   ones, cleared by wrap_clr, set wins). Without the macro wrap_flag is 0.
//
// Ports
//   clk        in   clock, rising edge active
//   rst_n      in   asynchronous active-low reset
//   load       in   load load_val into sp (idle only, lowest priority)
//   load_val   in   [WIDTH]   new stack pointer value
//   push_req   in   start a push of count bytes (highest priority)
//   pull_req   in   start a pull of count bytes
//   count      in   [2]       bytes to transfer, 1..3 (0 ignores request)
//   busy       out  bus cycle in progress
//   mem_addr   out  [PAGE_W+WIDTH] {PAGE, byte address}
//   mem_we     out  push bus cycle strobe
//   mem_re     out  pull bus cycle strobe
//   byte_idx   out  [2]       byte index within transfer
//   done       out  final bus cycle of the transfer
//   sp         out  [WIDTH]   current stack pointer
//   wrap_flag  out  sticky wrap indication
//   wrap_clr   in   clear for wrap_flag
// -----------------------------------------------------------------------------
module stack_unit #(
   parameter int                 WIDTH    = 8,
   parameter int                 PAGE_W   = 8,
   parameter logic [PAGE_W-1:0]  PAGE     = 8'h01,
   parameter logic [WIDTH-1:0]   RESET_SP = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load,
   input  logic [WIDTH-1:0]           load_val,
   input  logic                       push_req,
   input  logic                       pull_req,
   input  logic [1:0]                 count,
   output logic                       busy,
   output logic [PAGE_W+WIDTH-1:0]    mem_addr,
   output logic                       mem_we,
   output logic                       mem_re,
   output logic [1:0]                 byte_idx,
   output logic                       done,
   output logic [WIDTH-1:0]           sp,
   output logic                       wrap_flag,
   input  logic                       wrap_clr
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PUSH = 2'd1;
   localparam logic [1:0] S_PULL = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_sp;
   logic [1:0]       r_cnt;
   logic [1:0]       r_idx;

   logic             w_busy;
   logic             w_last;
   logic             w_req;
   logic             w_can_start;
   logic             w_wrap_set;
   logic [WIDTH-1:0] w_sp_inc;
   logic [WIDTH-1:0] w_sp_dec;

   assign w_busy   = (r_state != S_IDLE);
   assign w_last   = w_busy && (r_idx == (r_cnt - 2'd1));
   assign w_sp_inc = r_sp + WIDTH'(1);
   assign w_sp_dec = r_sp - WIDTH'(1);

   // A request with count 0 is treated as absent. The final bus cycle returns
   // to idle at its closing edge, so a request seen in that cycle starts the
   // next transfer back-to-back.
   assign w_req       = (push_req || pull_req) && (count != 2'd0);
   assign w_can_start = !w_busy || w_last;

   assign w_wrap_set  = ((r_state == S_PUSH) && (r_sp == '0)) ||
                        ((r_state == S_PULL) && (r_sp == '1));

   assign busy     = w_busy;
   assign mem_we   = (r_state == S_PUSH);
   assign mem_re   = (r_state == S_PULL);
   assign done     = w_last;
   assign byte_idx = w_busy ? r_idx : 2'd0;
   assign sp       = r_sp;
   assign mem_addr = {PAGE, (r_state == S_PULL) ? w_sp_inc : r_sp};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_sp    <= RESET_SP;
         r_cnt   <= 2'd0;
         r_idx   <= 2'd0;
      end else begin
         case (r_state)
            S_PUSH:  r_sp <= w_sp_dec;
            S_PULL:  r_sp <= w_sp_inc;
            default: if (load && !w_req) r_sp <= load_val;
         endcase

         if (w_busy) begin
            r_idx <= r_idx + 2'd1;
            if (w_last) r_state <= S_IDLE;
         end

         // Starting a transfer overrides the end-of-transfer update above.
         if (w_can_start && w_req) begin
            r_state <= push_req ? S_PUSH : S_PULL;
            r_cnt   <= count;
            r_idx   <= 2'd0;
         end
      end
   end

`ifdef STACK_WRAP_DET_EN
   logic r_wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrap <= 1'b0;
      end else if (w_wrap_set) begin
         r_wrap <= 1'b1;
      end else if (wrap_clr) begin
         r_wrap <= 1'b0;
      end
   end

   assign wrap_flag = r_wrap;
`else
   logic w_unused_wrap;

   assign w_unused_wrap = wrap_clr ^ w_wrap_set;
   assign wrap_flag     = 1'b0;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_unit
//   Self-checking bench for stack_unit. A transaction-level model turns each
//   accepted request into a queue of expected bus cycles computed directly
//   from the push/pull address rules; outputs are compared every cycle on the
//   falling edge. Honours STACK_WRAP_DET_EN for the wrap_flag expectation.
// -----------------------------------------------------------------------------
module tb_stack_unit;

   localparam logic [7:0] PAGE     = 8'h01;
   localparam logic [7:0] RESET_SP = 8'h00;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [7:0]  load_val;
   logic        push_req;
   logic        pull_req;
   logic [1:0]  count;
   logic        busy;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic        mem_re;
   logic [1:0]  byte_idx;
   logic        done;
   logic [7:0]  sp;
   logic        wrap_flag;
   logic        wrap_clr;

   stack_unit #(
      .WIDTH    (8),
      .PAGE_W   (8),
      .PAGE     (PAGE),
      .RESET_SP (RESET_SP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_val  (load_val),
      .push_req  (push_req),
      .pull_req  (pull_req),
      .count     (count),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .byte_idx  (byte_idx),
      .done      (done),
      .sp        (sp),
      .wrap_flag (wrap_flag),
      .wrap_clr  (wrap_clr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic        re;
      logic [1:0]  idx;
      logic        last;
      logic [7:0]  nsp;
      logic        wrap;
   } bus_t;

   bus_t       q[$];
   logic [7:0] m_sp   = RESET_SP;
   logic       m_wrap = 1'b0;

   task automatic m_reset();
      q.delete();
      m_sp   = RESET_SP;
      m_wrap = 1'b0;
   endtask

   // Expand one accepted request into its bus cycles.
   task automatic m_start(input bit is_push, input int n);
      bus_t       e;
      logic [7:0] a;
      for (int k = 0; k < n; k++) begin
         if (is_push) begin
            a      = m_sp - 8'(k);
            e.nsp  = a - 8'd1;
            e.wrap = (a == 8'h00);
         end else begin
            a      = m_sp + 8'(k + 1);
            e.nsp  = a;
            e.wrap = (a == 8'h00);
         end
         e.addr = {PAGE, a};
         e.we   = is_push;
         e.re   = !is_push;
         e.idx  = 2'(k);
         e.last = (k == n - 1);
         q.push_back(e);
      end
   endtask

   task automatic m_edge(input logic p, input logic l, input logic ld,
                         input logic [1:0] c, input logic [7:0] v, input logic clr);
      bus_t e;
      bit   can_start = 1'b1;
      bit   idle      = 1'b1;
      bit   setw      = 1'b0;
      if (q.size() > 0) begin
         e         = q.pop_front();
         m_sp      = e.nsp;
         setw      = e.wrap;
         idle      = 1'b0;
         can_start = (q.size() == 0);
      end
      if (can_start && (p || l) && c != 2'd0) m_start(p, int'(c));
      else if (idle && ld) m_sp = v;
`ifdef STACK_WRAP_DET_EN
      if (setw) m_wrap = 1'b1;
      else if (clr) m_wrap = 1'b0;
`else
      if (setw || clr) m_wrap = 1'b0;
`endif
   endtask

   task automatic check_outputs();
      if (q.size() > 0) begin
         chk("busy",     32'(busy),     32'd1);
         chk("mem_addr", 32'(mem_addr), 32'(q[0].addr));
         chk("mem_we",   32'(mem_we),   32'(q[0].we));
         chk("mem_re",   32'(mem_re),   32'(q[0].re));
         chk("byte_idx", 32'(byte_idx), 32'(q[0].idx));
         chk("done",     32'(done),     32'(q[0].last));
      end else begin
         chk("busy",     32'(busy),     32'd0);
         chk("mem_addr", 32'(mem_addr), 32'({PAGE, m_sp}));
         chk("mem_we",   32'(mem_we),   32'd0);
         chk("mem_re",   32'(mem_re),   32'd0);
         chk("byte_idx", 32'(byte_idx), 32'd0);
         chk("done",     32'(done),     32'd0);
      end
      chk("sp",        32'(sp),        32'(m_sp));
      chk("wrap_flag", 32'(wrap_flag), 32'(m_wrap));
   endtask

   // One clock: check at the falling edge, drive, advance the model with the DUT.
   task automatic cycle(input logic p, input logic l, input logic ld,
                        input logic [1:0] c, input logic [7:0] v, input logic clr);
      check_outputs();
      push_req = p;
      pull_req = l;
      load     = ld;
      count    = c;
      load_val = v;
      wrap_clr = clr;
      @(posedge clk);
      m_edge(p, l, ld, c, v, clr);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
   endtask

   initial begin
      rst_n    = 1'b0;
      load     = 1'b0;
      load_val = 8'h00;
      push_req = 1'b0;
      pull_req = 1'b0;
      count    = 2'd0;
      wrap_clr = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;

      // Load FD, push 3 bytes: FD, FC, FB, then sp FA.
      cycle(1'b0, 1'b0, 1'b1, 2'd0, 8'hFD, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0);
      idle(3);
      chk("sp_after_push3", 32'(sp), 32'h0000_00FA);

      // Pull 2 bytes from FA: FB, FC, then sp FC.
      cycle(1'b0, 1'b1, 1'b0, 2'd2, 8'h00, 1'b0);
      idle(2);
      chk("sp_after_pull2", 32'(sp), 32'h0000_00FC);

      // Push 3 across zero: 0101, 0100, 01FF, then sp FE and wrap.
      cycle(1'b0, 1'b0, 1'b1, 2'd0, 8'h01, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0);
      idle(3);
      chk("sp_after_wrap", 32'(sp), 32'h0000_00FE);
`ifdef STACK_WRAP_DET_EN
      chk("wrap_set", 32'(wrap_flag), 32'd1);
`else
      chk("wrap_off", 32'(wrap_flag), 32'd0);
`endif
      idle(1);
      cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
      chk("wrap_cleared", 32'(wrap_flag), 32'd0);

      // All three requests at once: one push, load discarded.
      cycle(1'b1, 1'b1, 1'b1, 2'd1, 8'h55, 1'b0);
      idle(1);
      chk("sp_prio", 32'(sp), 32'h0000_00FD);

      // Count 0 push is ignored; push while busy (not final cycle) is ignored.
      cycle(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
      chk("cnt0_busy", 32'(busy), 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0);
      idle(2);
      chk("sp_busy_ignore", 32'(sp), 32'h0000_00FA);

      // Back-to-back: request during the final cycle starts the next transfer.
      cycle(1'b0, 1'b1, 1'b0, 2'd1, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 2'd2, 8'h00, 1'b0);
      idle(3);

      // Asynchronous reset in the second cycle of a 3-byte push.
      cycle(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0);
      idle(1);
      chk("rst_pre_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      m_reset();
      chk("rst_busy",   32'(busy),     32'd0);
      chk("rst_we",     32'(mem_we),   32'd0);
      chk("rst_re",     32'(mem_re),   32'd0);
      chk("rst_done",   32'(done),     32'd0);
      chk("rst_idx",    32'(byte_idx), 32'd0);
      chk("rst_sp",     32'(sp),       32'(RESET_SP));
      chk("rst_wrap",   32'(wrap_flag), 32'd0);
      chk("rst_addr",   32'(mem_addr), 32'({PAGE, RESET_SP}));
      @(posedge clk);
      #1 chk("rst_no_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
               8'($urandom), ($urandom_range(0, 7) == 0));
      end
      check_outputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
